// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem requests and drives IF/ID.
// One-entry side buffer parks an instruction that returns while IF/ID is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_IFID,
  output logic [31:0] pc_IFID,
  output logic        valid_IFID
);

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic        r_buf_vld;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_ifid;
  logic        r_valid;

  logic [31:0] w_pc_inc;
  logic [31:0] w_target;

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_target  = branch_target & ~32'h3;
  assign imem_req  = !reset && ((r_state == S_FETCH && !r_buf_vld) || r_state == S_DROP);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign instr_IFID = r_instr;
  assign pc_IFID    = r_pc_ifid;
  assign valid_IFID = r_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_instr <= NOP_INSTR;
      r_buf_pc    <= '0;
      r_instr     <= NOP_INSTR;
      r_pc_ifid   <= '0;
      r_valid     <= 1'b0;
    end else if (flush) begin
      r_instr   <= NOP_INSTR;
      r_pc_ifid <= '0;
      r_valid   <= 1'b0;
      r_buf_vld <= 1'b0;
      r_pc      <= w_target;
      // An outstanding request must still complete; remember where it went.
      if (r_state == S_FETCH) begin
        if (imem_req && !imem_ready) begin
          r_drop_addr <= imem_addr;
          r_state     <= S_DROP;
        end
      end
    end else if (r_state == S_DROP) begin
      if (!stall_IFID) begin
        r_instr   <= NOP_INSTR;
        r_pc_ifid <= '0;
        r_valid   <= 1'b0;
      end
      if (imem_ready) begin
        r_state <= S_FETCH;
      end
    end else if (stall_IFID) begin
      if (!r_buf_vld && imem_ready) begin
        r_buf_instr <= imem_rdata;
        r_buf_pc    <= r_pc;
        r_buf_vld   <= 1'b1;
        r_pc        <= w_pc_inc;
      end
    end else if (r_buf_vld) begin
      r_instr   <= r_buf_instr;
      r_pc_ifid <= r_buf_pc;
      r_valid   <= 1'b1;
      r_buf_vld <= 1'b0;
    end else if (imem_ready) begin
      r_instr   <= imem_rdata;
      r_pc_ifid <= r_pc;
      r_valid   <= 1'b1;
      r_pc      <= w_pc_inc;
    end else begin
      r_instr   <= NOP_INSTR;
      r_pc_ifid <= '0;
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted cycles with a program-order scoreboard that is
// popped whenever decode would consume IF/ID, plus direct per-cycle checks.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_IFID;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_IFID;
  logic [31:0] pc_IFID;
  logic        valid_IFID;
  logic        rdy_en;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_0013;
  endfunction

  assign imem_ready = rdy_en & imem_req;
  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(NOP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall_IFID   (stall_IFID),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_IFID   (instr_IFID),
    .pc_IFID      (pc_IFID),
    .valid_IFID   (valid_IFID)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic fl, input logic [31:0] bt,
                     input logic rdy, input logic rst);
    @(posedge clock);
    #1;
    stall_IFID    = st;
    flush         = fl;
    branch_target = bt;
    rdy_en        = rdy;
    reset         = rst;
    #1;
  endtask

  // Decode consumes IF/ID at a clock edge when it is valid and not stalled or squashed.
  always @(negedge clock) begin
    if (reset === 1'b0 && valid_IFID === 1'b1 && !stall_IFID && !flush) begin
      check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        check("sb_pc", pc_IFID, exp_pc);
        check("sb_instr", instr_IFID, mem_word(exp_pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall_IFID = 1'b0; flush = 1'b0; branch_target = '0; rdy_en = 1'b1;
    @(posedge clock); #2;
    check("rst_req", imem_req, 0);
    check("rst_vld", valid_IFID, 0);
    check("rst_instr", instr_IFID, NOP);
    check("rst_pc", pc_IFID, 0);

    cyc(0, 0, 0, 1, 0);
    check("a_req", imem_req, 1);
    check("a_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'h100);
    check("b_pc", pc_IFID, 32'h100);
    check("b_vld", valid_IFID, 1);
    // Stall three cycles: 0x108 parks in the buffer, then no more requests.
    cyc(1, 0, 0, 1, 0);
    check("c_pc", pc_IFID, 32'h104);
    check("c_addr", imem_addr, 32'h108);
    cyc(1, 0, 0, 1, 0);
    check("d_req", imem_req, 0);
    check("d_pc", pc_IFID, 32'h104);
    cyc(1, 0, 0, 1, 0);
    check("e_req", imem_req, 0);
    check("e_pc", pc_IFID, 32'h104);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'h104);
    check("f_req", imem_req, 0);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'h108);
    check("g_pc", pc_IFID, 32'h108);
    check("g_addr", imem_addr, 32'h10C);
    cyc(0, 0, 0, 0, 0); exp_q.push_back(32'h10C);
    check("h_pc", pc_IFID, 32'h10C);
    check("h_addr", imem_addr, 32'h110);
    // Flush while the request to 0x110 is still waiting.
    cyc(0, 1, 32'h400, 0, 0);
    check("i_addr", imem_addr, 32'h110);
    check("i_vld", valid_IFID, 0);
    cyc(0, 0, 0, 0, 0);
    check("j_addr", imem_addr, 32'h110);
    check("j_req", imem_req, 1);
    cyc(0, 0, 0, 0, 0);
    check("k_addr", imem_addr, 32'h110);
    cyc(0, 0, 0, 1, 0);
    check("l_addr", imem_addr, 32'h110);
    cyc(0, 0, 0, 1, 0);
    check("m_vld", valid_IFID, 0);
    check("m_addr", imem_addr, 32'h400);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'h400);
    check("n_pc", pc_IFID, 32'h400);
    // Flush with a misaligned target and a same-cycle response.
    cyc(0, 1, 32'h203, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("p_vld", valid_IFID, 0);
    check("p_instr", instr_IFID, NOP);
    check("p_pc", pc_IFID, 0);
    check("p_addr", imem_addr, 32'h200);
    cyc(1, 0, 0, 1, 0);
    check("q_pc", pc_IFID, 32'h200);
    check("q_vld", valid_IFID, 1);
    // Flush and stall together with the buffer full.
    cyc(1, 1, 32'h500, 1, 0);
    check("r_req", imem_req, 0);
    cyc(0, 0, 0, 1, 0);
    check("s_vld", valid_IFID, 0);
    check("s_req", imem_req, 1);
    check("s_addr", imem_addr, 32'h500);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'h500);
    check("t_pc", pc_IFID, 32'h500);
    // PC wrap-around at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFE, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("v_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 0); exp_q.push_back(32'hFFFF_FFFC);
    check("w_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0); exp_q.push_back(32'h0);
    check("x_addr", imem_addr, 32'h4);
    check("x_pc", pc_IFID, 32'h0);
    // Reset during a waiting request.
    cyc(0, 0, 0, 0, 1);
    check("y_req", imem_req, 0);
    cyc(0, 0, 0, 1, 0);
    check("z_req", imem_req, 1);
    check("z_addr", imem_addr, 32'h100);
    check("z_vld", valid_IFID, 0);
    cyc(0, 0, 0, 0, 0); exp_q.push_back(32'h100);
    check("aa_pc", pc_IFID, 32'h100);
    cyc(0, 0, 0, 0, 0);
    @(negedge clock); #1;
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Consumes the hazard unit's stall_IFID/flush outputs and acts on them: owns the PC, issues instruction-memory requests and drives the IF/ID pipeline register.
- Inserts bubbles on flush or slow memory.
- Holds IF/ID on stall, parking at most one early-returning instruction in a one-entry buffer.
- Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding driven as a bubble (addi x0,x0,0).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- stall_IFID  in  1  hold IF/ID register and PC (from hazard unit).
- flush  in  1  squash IF/ID and redirect PC (from hazard unit).
- branch_target  in  32  redirect address, sampled when flush=1.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  response valid this cycle; imem_rdata valid when high.
- imem_rdata  in  32  fetched instruction.
- instr_IFID  out  32  IF/ID instruction.
- pc_IFID  out  32  PC of instr_IFID.
- valid_IFID  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (sync, priority over all):
  - pc=RESET_PC, state=FETCH.
  - instr_IFID=NOP_INSTR, pc_IFID=0, valid_IFID=0, buffer empty.
  - imem_req=0 during the reset cycle.
  - Reset mid-request abandons it; memory is reset on the same reset.
- States: FETCH, DROP.
- imem_req = !reset && ((state==FETCH && !buf_valid) || state==DROP).
- imem_addr = (state==DROP) ? drop_addr : pc.
- Memory protocol: imem_addr stays stable while imem_req=1 and imem_ready=0. Response is combinational with imem_ready; zero or more wait cycles.
- Priority per cycle: reset > flush > stall > normal.
- Flush:
  - IF/ID <= bubble (NOP_INSTR, valid 0, pc_IFID 0); buffer cleared.
  - pc <= {branch_target[31:2],2'b00}.
  - If imem_req=1 and imem_ready=0: drop_addr <= current imem_addr, state <= DROP.
  - Else state <= FETCH; a same-cycle response is discarded.
  - Flush in DROP: update pc only, stay DROP, drop_addr unchanged.
- DROP:
  - IF/ID loads a bubble every non-stalled cycle.
  - On imem_ready: discard data, state <= FETCH; next request uses pc one cycle later.
- Stall (flush=0, stall_IFID=1):
  - IF/ID holds all three outputs.
  - In FETCH with empty buffer and imem_ready=1: buffer <= imem_rdata with pc, buf_valid=1, pc <= pc+4.
  - Buffer full: no request issued.
- Normal (no flush, no stall, FETCH):
  - Buffer full: IF/ID <= buffer (valid 1), buffer cleared; request resumes next cycle.
  - Else imem_ready=1: IF/ID <= {imem_rdata, pc, 1}, pc <= pc+4.
  - Else: IF/ID <= bubble (valid 0); pc holds.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFFFFFC -> 32'h0). pc[1:0] is always 0.
- Single-cycle-ready memory with no hazards yields one instruction per cycle. Each instruction appears on IF/ID the cycle after its imem_ready.
- Buffer is used only during a stall. No instruction is lost or duplicated across stalls.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready tied 1, rdata=addr-derived -> pc_IFID sequence 0x100,0x104,0x108 on consecutive cycles, valid_IFID=1 from first post-reset fetch; imem_req=0 during reset cycle.
- Stall 3 cycles with ready=1 while pc_IFID=0x104 -> IF/ID holds 0x104; 0x108 buffered; imem_req=0 for stall cycles 2-3. After release, IF/ID=0x108, then 0x10C one cycle later.
- Flush, branch_target=0x203, ready=1 -> next IF/ID is bubble (NOP, valid 0); next imem_addr=0x200; instruction from 0x200 reaches IF/ID two cycles after flush.
- Flush while request to 0x110 waits (ready=0 for 2 more cycles) -> imem_addr stays 0x110 until ready; that data is discarded with valid_IFID=0. Next request is to the target.
- Flush and stall_IFID both high -> flush wins: IF/ID becomes bubble, buffer cleared, PC redirected.
- pc=0xFFFFFFFC fetch with ready=1 -> next imem_addr=0x00000000; reset asserted during a waiting request -> next cycle state FETCH, imem_req=0, valid_IFID=0, pc=RESET_PC.
